// File: rtl/reg_access_sequencer_pkg.sv
// Shared definitions for the register-file access sequencer: default widths,
// RF read/write select encoding, the x0 address and the FSM state encoding.
package reg_access_sequencer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // rf_r_or_w encoding; idle level is READ so the RF never sees a stray write
    localparam logic RF_READ  = 1'b1;
    localparam logic RF_WRITE = 1'b0;

    // x0 is hardwired to zero; the sequencer never writes it and masks its reads
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RS1  = 3'd2,
        RS2  = 3'd3,
        CAP  = 3'd4,
        RESP = 3'd5
    } state_t;

endpackage

// File: rtl/reg_access_sequencer_if.sv
// Bundle of the fetch-request, operand-response, writeback and register-file
// signals around the sequencer. master = sequencer side, slave = environment
// (decode/writeback stages plus the register file).
interface reg_access_sequencer_if
    import reg_access_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    // operand fetch request
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              use_rs2;

    // operand response
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    // writeback request
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    // register file port
    logic [ADDR_W-1:0] rf_read_addr;
    logic [ADDR_W-1:0] rf_write_addr;
    logic              rf_r_or_w;
    logic [DATA_W-1:0] rf_write_val;
    logic [DATA_W-1:0] rf_read_value;

    modport master (
        input  rd_req_valid, rs1_addr, rs2_addr, use_rs2,
        input  op_ready,
        input  wb_valid, wb_addr, wb_data,
        input  rf_read_value,
        output rd_req_ready, op_valid, rs1_data, rs2_data, wb_ready,
        output rf_read_addr, rf_write_addr, rf_r_or_w, rf_write_val
    );

    modport slave (
        output rd_req_valid, rs1_addr, rs2_addr, use_rs2,
        output op_ready,
        output wb_valid, wb_addr, wb_data,
        output rf_read_value,
        input  rd_req_ready, op_valid, rs1_data, rs2_data, wb_ready,
        input  rf_read_addr, rf_write_addr, rf_r_or_w, rf_write_val
    );

endinterface

// File: rtl/reg_access_sequencer.sv
// Initiator-side sequencer for a register file with one shared read/write
// select. Serialises writebacks and one- or two-operand fetches, masks x0
// reads to zero, and returns operands over a valid/ready handshake.
// Every rf_* and op output comes straight from a flop: the output process
// computes the value each register must hold in the *next* state.
module reg_access_sequencer
    import reg_access_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_access_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    state_t            state, state_nx;

    // latched fetch request
    logic [ADDR_W-1:0] rs1_q, rs1_nx;
    logic [ADDR_W-1:0] rs2_q, rs2_nx;
    logic              use_rs2_q, use_rs2_nx;

    // registered outputs
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_nx;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nx;
    logic [DATA_W-1:0] wr_val_q, wr_val_nx;
    logic              r_or_w_q, r_or_w_nx;
    logic              op_valid_q, op_valid_nx;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_nx;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_nx;

    // RF data as seen by the pipeline: x0 always reads as zero
    function automatic logic [DATA_W-1:0] mask_x0(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] v);
        return (a == ZERO_ADDR) ? '0 : v;
    endfunction

    // State and output registers; reset drops any in-flight request
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            use_rs2_q  <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_val_q   <= '0;
            r_or_w_q   <= RF_READ;
            op_valid_q <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            state      <= state_nx;
            rs1_q      <= rs1_nx;
            rs2_q      <= rs2_nx;
            use_rs2_q  <= use_rs2_nx;
            rd_addr_q  <= rd_addr_nx;
            wr_addr_q  <= wr_addr_nx;
            wr_val_q   <= wr_val_nx;
            r_or_w_q   <= r_or_w_nx;
            op_valid_q <= op_valid_nx;
            rs1_data_q <= rs1_data_nx;
            rs2_data_q <= rs2_data_nx;
        end
    end

    // Next-state: writeback beats fetch in IDLE since it is older in program order
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE: begin
                state_nx = IDLE;
                if (bus.wb_valid) begin
                    // a write to x0 retires here without touching the RF
                    if (bus.wb_addr != ZERO_ADDR) state_nx = WR;
                end else if (bus.rd_req_valid) begin
                    state_nx = RS1;
                end
            end
            WR:      state_nx = IDLE;
            RS1:     state_nx = use_rs2_q ? RS2 : CAP;
            RS2:     state_nx = CAP;
            CAP:     state_nx = RESP;
            RESP:    state_nx = bus.op_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Output/datapath next values; read data arrives one cycle after its address
    always_comb begin
        rs1_nx      = rs1_q;
        rs2_nx      = rs2_q;
        use_rs2_nx  = use_rs2_q;
        rd_addr_nx  = rd_addr_q;
        wr_addr_nx  = wr_addr_q;
        wr_val_nx   = wr_val_q;
        rs1_data_nx = rs1_data_q;
        rs2_data_nx = rs2_data_q;
        case (state)
            IDLE: begin
                if (bus.wb_valid) begin
                    if (bus.wb_addr != ZERO_ADDR) begin
                        wr_addr_nx = bus.wb_addr;
                        wr_val_nx  = bus.wb_data;
                    end
                end else if (bus.rd_req_valid) begin
                    rs1_nx     = bus.rs1_addr;
                    rs2_nx     = bus.rs2_addr;
                    use_rs2_nx = bus.use_rs2;
                    rd_addr_nx = bus.rs1_addr;
                end
            end
            RS1: begin
                if (use_rs2_q) rd_addr_nx = rs2_q;
            end
            RS2: begin
                rs1_data_nx = mask_x0(rs1_q, bus.rf_read_value);
            end
            CAP: begin
                if (use_rs2_q) begin
                    rs2_data_nx = mask_x0(rs2_q, bus.rf_read_value);
                end else begin
                    rs1_data_nx = mask_x0(rs1_q, bus.rf_read_value);
                    rs2_data_nx = '0;
                end
            end
            default: ;
        endcase
        // the write select is low only for the single WR cycle
        r_or_w_nx   = (state_nx == WR) ? RF_WRITE : RF_READ;
        op_valid_nx = (state_nx == RESP);
    end

    assign bus.wb_ready      = (state == IDLE);
    assign bus.rd_req_ready  = (state == IDLE) & ~bus.wb_valid;
    assign bus.op_valid      = op_valid_q;
    assign bus.rs1_data      = rs1_data_q;
    assign bus.rs2_data      = rs2_data_q;
    assign bus.rf_read_addr  = rd_addr_q;
    assign bus.rf_write_addr = wr_addr_q;
    assign bus.rf_write_val  = wr_val_q;
    assign bus.rf_r_or_w     = r_or_w_q;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Self-checking bench: behavioural RF on the rf_* port, an architectural
// register array as reference, directed scenarios plus a random mix.
module tb_reg_access_sequencer;
    import reg_access_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   errors = 0;
    int   wr_pulses = 0;
    logic rf_loaded = 1'b0;

    logic [31:0] rf_mem [32];
    logic [31:0] ref_regs [32];

    always #5 clk = ~clk;

    reg_access_sequencer_if bus ();

    reg_access_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // x0 in the RF model holds garbage so masking on the initiator side is visible
    function automatic logic [31:0] rf_init(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // Register file: synchronous read, write at the end of a write cycle
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= rf_init(i);
            rf_loaded <= 1'b1;
        end else if (bus.rf_r_or_w === RF_WRITE) begin
            rf_mem[bus.rf_write_addr] <= bus.rf_write_val;
        end
        bus.rf_read_value <= rf_mem[bus.rf_read_addr];
    end

    // count cycles the RF is asked to write
    always @(posedge clk) begin
        if (reset === 1'b0 && bus.rf_r_or_w === RF_WRITE) wr_pulses <= wr_pulses + 1;
    end

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        while (bus.wb_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        tests++;
        if (bus.wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL wb_ready_timeout: got %b want 1", bus.wb_ready);
        end
        bus.wb_valid = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        if (a != 5'd0) ref_regs[a] = d;
    endtask

    // issue a fetch and wait for op_valid; lat = edges after the accepting edge
    task automatic do_fetch(input logic [4:0] a1, input logic [4:0] a2, input logic u,
                            output logic [31:0] d1, output logic [31:0] d2, output int lat);
        int n = 0;
        while (bus.rd_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        tests++;
        if (bus.rd_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_req_ready_timeout: got %b want 1", bus.rd_req_ready);
        end
        bus.rd_req_valid = 1'b1; bus.rs1_addr = a1; bus.rs2_addr = a2; bus.use_rs2 = u;
        @(posedge clk); #1;
        bus.rd_req_valid = 1'b0;
        lat = 0;
        while (bus.op_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        d1 = bus.rs1_data;
        d2 = bus.rs2_data;
    endtask

    task automatic do_ack();
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        tests++;
        if (bus.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_clears_op_valid: got %b want 0", bus.op_valid);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        tests += 9;
        if (bus.op_valid !== 1'b0)      begin errors++; $display("FAIL rst_op_valid: got %b want 0", bus.op_valid); end
        if (bus.rf_r_or_w !== 1'b1)     begin errors++; $display("FAIL rst_r_or_w: got %b want 1", bus.rf_r_or_w); end
        if (bus.rf_read_addr !== 5'd0)  begin errors++; $display("FAIL rst_read_addr: got %h want 0", bus.rf_read_addr); end
        if (bus.rf_write_addr !== 5'd0) begin errors++; $display("FAIL rst_write_addr: got %h want 0", bus.rf_write_addr); end
        if (bus.rf_write_val !== 32'd0) begin errors++; $display("FAIL rst_write_val: got %h want 0", bus.rf_write_val); end
        if (bus.rs1_data !== 32'd0)     begin errors++; $display("FAIL rst_rs1_data: got %h want 0", bus.rs1_data); end
        if (bus.rs2_data !== 32'd0)     begin errors++; $display("FAIL rst_rs2_data: got %h want 0", bus.rs2_data); end
        if (bus.rd_req_ready !== 1'b1)  begin errors++; $display("FAIL rst_rd_req_ready: got %b want 1", bus.rd_req_ready); end
        if (bus.wb_ready !== 1'b1)      begin errors++; $display("FAIL rst_wb_ready: got %b want 1", bus.wb_ready); end
    endtask

    task automatic test_writes_then_fetch();
        logic [31:0] d1, d2;
        int lat, p0;
        p0 = wr_pulses;
        do_wb(5'd4, 32'h12);
        do_wb(5'd20, 32'h2);
        do_wb(5'd5, 32'hA);
        do_fetch(5'd5, 5'd4, 1'b1, d1, d2, lat);
        tests += 4;
        if (wr_pulses - p0 != 3) begin errors++; $display("FAIL wr_pulse_count: got %0d want 3", wr_pulses - p0); end
        if (lat != 3)            begin errors++; $display("FAIL lat_two_operands: got %0d want 3", lat); end
        if (d1 !== 32'hA)        begin errors++; $display("FAIL fetch_x5: got %h want 0000000a", d1); end
        if (d2 !== 32'h12)       begin errors++; $display("FAIL fetch_x4: got %h want 00000012", d2); end
        do_ack();
    endtask

    task automatic test_single_operand();
        logic [31:0] d1, d2;
        int lat;
        do_fetch(5'd20, 5'd7, 1'b0, d1, d2, lat);
        tests += 3;
        if (lat != 2)      begin errors++; $display("FAIL lat_one_operand: got %0d want 2", lat); end
        if (d1 !== 32'h2)  begin errors++; $display("FAIL fetch_x20: got %h want 00000002", d1); end
        if (d2 !== 32'h0)  begin errors++; $display("FAIL rs2_zero_unused: got %h want 0", d2); end
        do_ack();
    endtask

    task automatic test_x0();
        logic [31:0] d1, d2;
        int lat, p0;
        p0 = wr_pulses;
        do_wb(5'd0, 32'hFFFF_FFFF);
        do_fetch(5'd0, 5'd4, 1'b1, d1, d2, lat);
        tests += 3;
        if (wr_pulses != p0) begin errors++; $display("FAIL x0_no_write: got %0d pulses want 0", wr_pulses - p0); end
        if (d1 !== 32'h0)    begin errors++; $display("FAIL x0_reads_zero: got %h want 0", d1); end
        if (d2 !== 32'h12)   begin errors++; $display("FAIL x0_rs2_x4: got %h want 00000012", d2); end
        do_ack();
    endtask

    task automatic test_priority();
        int n = 0;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h55;
        bus.rd_req_valid = 1'b1; bus.rs1_addr = 5'd6; bus.rs2_addr = 5'd0; bus.use_rs2 = 1'b0;
        #1;
        tests += 2;
        if (bus.rd_req_ready !== 1'b0) begin errors++; $display("FAIL prio_rd_req_ready: got %b want 0", bus.rd_req_ready); end
        if (bus.wb_ready !== 1'b1)     begin errors++; $display("FAIL prio_wb_ready: got %b want 1", bus.wb_ready); end
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        ref_regs[6] = 32'h55;
        while (bus.rd_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.rd_req_valid = 1'b0;
        n = 0;
        while (bus.op_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        tests++;
        if (bus.rs1_data !== 32'h55) begin errors++; $display("FAIL prio_fetch_x6: got %h want 00000055", bus.rs1_data); end
        do_ack();
    endtask

    task automatic test_stall();
        logic [31:0] d1, d2;
        int lat, bad = 0;
        do_fetch(5'd5, 5'd20, 1'b1, d1, d2, lat);
        tests += 2;
        if (d1 !== ref_regs[5])  begin errors++; $display("FAIL stall_rs1: got %h want %h", d1, ref_regs[5]); end
        if (d2 !== ref_regs[20]) begin errors++; $display("FAIL stall_rs2: got %h want %h", d2, ref_regs[20]); end
        bus.rd_req_valid = 1'b1; bus.rs1_addr = 5'd4; bus.use_rs2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.op_valid !== 1'b1 || bus.rs1_data !== d1 || bus.rs2_data !== d2 || bus.rd_req_ready !== 1'b0) bad++;
        end
        bus.rd_req_valid = 1'b0;
        tests++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
        do_ack();
    endtask

    task automatic test_reset_midop();
        int rose = 0;
        bus.rd_req_valid = 1'b1; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd4; bus.use_rs2 = 1'b1;
        @(posedge clk); #1;
        bus.rd_req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests += 4;
        if (bus.op_valid !== 1'b0)     begin errors++; $display("FAIL midrst_op_valid: got %b want 0", bus.op_valid); end
        if (bus.rd_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b want 1", bus.rd_req_ready); end
        if (bus.rf_read_addr !== 5'd0) begin errors++; $display("FAIL midrst_read_addr: got %h want 0", bus.rf_read_addr); end
        if (bus.rs1_data !== 32'd0)    begin errors++; $display("FAIL midrst_rs1_data: got %h want 0", bus.rs1_data); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.op_valid === 1'b1) rose++;
        end
        tests++;
        if (rose != 0) begin errors++; $display("FAIL midrst_op_valid_rose: got %0d cycles want 0", rose); end
    endtask

    task automatic test_random();
        logic [31:0] d1, d2, e2;
        logic [4:0]  a1, a2;
        logic        u;
        int lat, p0, nwr = 0;
        p0 = wr_pulses;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                a1 = 5'($urandom_range(0, 31));
                if (a1 != 5'd0) nwr++;
                do_wb(a1, $urandom);
            end else begin
                a1 = 5'($urandom_range(0, 31));
                a2 = 5'($urandom_range(0, 31));
                u  = 1'($urandom_range(0, 1));
                do_fetch(a1, a2, u, d1, d2, lat);
                e2 = u ? ((a2 == 5'd0) ? 32'd0 : ref_regs[a2]) : 32'd0;
                tests += 3;
                if (lat != (u ? 3 : 2)) begin errors++; $display("FAIL rnd_lat it%0d: got %0d want %0d", it, lat, u ? 3 : 2); end
                if (d1 !== ((a1 == 5'd0) ? 32'd0 : ref_regs[a1]))
                    begin errors++; $display("FAIL rnd_rs1 it%0d x%0d: got %h want %h", it, a1, d1, (a1 == 5'd0) ? 32'd0 : ref_regs[a1]); end
                if (d2 !== e2) begin errors++; $display("FAIL rnd_rs2 it%0d x%0d: got %h want %h", it, a2, d2, e2); end
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_ack();
            end
        end
        tests++;
        if (wr_pulses - p0 != nwr) begin errors++; $display("FAIL rnd_wr_pulses: got %0d want %0d", wr_pulses - p0, nwr); end
    endtask

    initial begin
        bus.rd_req_valid = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0; bus.use_rs2 = 1'b0;
        bus.op_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        for (int i = 0; i < 32; i++) ref_regs[i] = (i == 0) ? 32'd0 : rf_init(i);
        test_reset();
        test_writes_then_fetch();
        test_single_operand();
        test_x0();
        test_priority();
        test_stall();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
